// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the divide-by-zero quotient constant.
package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'b000;
   localparam logic [2:0] MDU_MULTU = 3'b001;
   localparam logic [2:0] MDU_DIV   = 3'b010;
   localparam logic [2:0] MDU_DIVU  = 3'b011;
   localparam logic [2:0] MDU_MADD  = 3'b100;
   localparam logic [2:0] MDU_MADDU = 3'b101;
   localparam logic [2:0] MDU_MSUB  = 3'b110;
   localparam logic [2:0] MDU_MSUBU = 3'b111;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;

   // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
   localparam int                       MDU_MAX_WIDTH = 64;
   localparam logic [MDU_MAX_WIDTH-1:0] MDU_DIV0_QUOT = '1;

   // Even op codes are the signed variants.
   function automatic logic op_is_signed(input logic [2:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return op[2:1] == 2'b01;
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor, keep the difference when it does not go negative.
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // NOTE: combinational logic uses blocking assignments and assigns every
   // output on every path, so no latch can be inferred.
   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {1'b0, div_i};
      q_o     = ~diff[WIDTH];
      rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with start/ready handshake and annul.
// Define MDU_MADD_EN to build the MADD/MADDU/MSUB/MSUBU accumulate adder.
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [2:0]         op_i,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [WIDTH-1:0]   opb_i,
   input  logic [2*WIDTH-1:0] hilo_i,
   input  logic               annul_i,
   output logic               busy_o,
   output logic               ready_o,
   output logic [2*WIDTH-1:0] result_o
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0]   a_mag_q, a_mag_d;
   logic [WIDTH-1:0]   b_mag_q, b_mag_d;
   logic               neg_q, neg_d;
   logic               a_neg_q, a_neg_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [CW-1:0]      cnt_q, cnt_d;
`ifdef MDU_MADD_EN
   logic [2:0]         op_q, op_d;
   logic [2*WIDTH-1:0] hilo_q, hilo_d;
`endif

   logic               sgn;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   step_rem;
   logic               step_q;

   mdu_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .div_i (b_mag_q),
      .bit_i (quo_q[WIDTH-1]),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      a_mag_d  = a_mag_q;
      b_mag_d  = b_mag_q;
      neg_d    = neg_q;
      a_neg_d  = a_neg_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
`ifdef MDU_MADD_EN
      op_d     = op_q;
      hilo_d   = hilo_q;
`endif
      sgn    = op_is_signed(op_i);
      prod   = {{WIDTH{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q};
      prod_s = neg_q ? -prod : prod;

      if (annul_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (start_i) begin
               a_mag_d = (sgn && opa_i[WIDTH-1]) ? -opa_i : opa_i;
               b_mag_d = (sgn && opb_i[WIDTH-1]) ? -opb_i : opb_i;
               neg_d   = sgn && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
               a_neg_d = sgn && opa_i[WIDTH-1];
`ifdef MDU_MADD_EN
               op_d    = op_i;
               hilo_d  = hilo_i;
`endif
               if (op_is_div(op_i)) begin
                  if (opb_i == '0) begin
                     result_d = {opa_i, MDU_DIV0_QUOT[WIDTH-1:0]};
                     state_d  = DONE;
                  end else begin
                     rem_d   = '0;
                     quo_d   = (sgn && opa_i[WIDTH-1]) ? -opa_i : opa_i;
                     cnt_d   = '0;
                     state_d = DIV;
                  end
               end else if (op_i[2]) begin
`ifdef MDU_MADD_EN
                  state_d  = MUL;
`else
                  result_d = hilo_i;
                  state_d  = DONE;
`endif
               end else begin
                  state_d = MUL;
               end
            end
            MUL: begin
               result_d = prod_s;
`ifdef MDU_MADD_EN
               if (op_q[2]) result_d = op_q[1] ? hilo_q - prod_s : hilo_q + prod_s;
`endif
               state_d = DONE;
            end
            DIV: begin
               rem_d = step_rem;
               quo_d = {quo_q[WIDTH-2:0], step_q};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
               result_d = {a_neg_q ? -rem_q : rem_q, neg_q ? -quo_q : quo_q};
               state_d  = DONE;
            end
            DONE: if (!start_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      busy_d  = (state_d == MUL) || (state_d == DIV) || (state_d == FIX);
      ready_d = !annul_i && (state_q == DONE) && start_i;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         neg_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
`ifdef MDU_MADD_EN
         op_q     <= '0;
         hilo_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         result_q <= result_d;
         a_mag_q  <= a_mag_d;
         b_mag_q  <= b_mag_d;
         neg_q    <= neg_d;
         a_neg_q  <= a_neg_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
`ifdef MDU_MADD_EN
         op_q     <= op_d;
         hilo_q   <= hilo_d;
`endif
      end
   end

   assign busy_o   = busy_q;
   assign ready_o  = ready_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table plus annul and reset sequences,
// with expected results held in a scoreboard queue.
module tb_mdu;
   import mdu_pkg::*;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start_i;
   logic [2:0]     op_i;
   logic [W-1:0]   opa_i;
   logic [W-1:0]   opb_i;
   logic [2*W-1:0] hilo_i;
   logic           annul_i;
   logic           busy_o;
   logic           ready_o;
   logic [2*W-1:0] result_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string          name;
      logic [2:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] hilo;
      logic [2*W-1:0] res;
      int             lat;
   } vec_t;

   vec_t           vecs[$];
   logic [2*W-1:0] sb_q[$];

   mdu #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .op_i     (op_i),
      .opa_i    (opa_i),
      .opb_i    (opb_i),
      .hilo_i   (hilo_i),
      .annul_i  (annul_i),
      .busy_o   (busy_o),
      .ready_o  (ready_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] hilo,
                          input logic [2*W-1:0] res, input int lat);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.hilo = hilo; v.res = res; v.lat = lat;
      vecs.push_back(v);
   endtask

   // start_i is already high; count edges from the next posedge (edge 0).
   task automatic measure(input string name, input int lat);
      int             seen;
      logic [2*W-1:0] exp;
      logic [2*W-1:0] held;
      seen = -1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            check({name, " busy_edge0"}, 64'(busy_o), 64'(lat > 1));
            op_i   = 3'($urandom);
            opa_i  = $urandom;
            opb_i  = $urandom;
            hilo_i = {$urandom, $urandom};
         end
         if (ready_o) begin
            seen = k;
            break;
         end
      end
      check({name, " latency"}, 64'(seen), 64'(lat));
      exp = sb_q.pop_front();
      if (seen >= 0) begin
         check({name, " result"}, result_o, exp);
         held = result_o;
         @(posedge clk); #1;
         check({name, " hold"}, {63'd0, ready_o} | ((result_o ^ held) << 1), 64'd1);
      end
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      check({name, " release"}, {62'd0, busy_o, ready_o}, 64'd0);
   endtask

   task automatic run_op(input vec_t v);
      @(negedge clk);
      op_i = v.op; opa_i = v.a; opb_i = v.b; hilo_i = v.hilo; start_i = 1'b1;
      sb_q.push_back(v.res);
      measure(v.name, v.lat);
   endtask

   initial begin
      int   ready_seen;
      vec_t v;

      rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
      op_i = '0; opa_i = '0; opb_i = '0; hilo_i = '0;

      add_vec("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'h3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA, 2);
      add_vec("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001, 2);
      add_vec("mult_minmin", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000, 2);
`ifdef MDU_MADD_EN
      add_vec("maddu_carry", MDU_MADDU, 32'h1, 32'h1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0001_0000_0000, 2);
      add_vec("msub_zero", MDU_MSUB, 32'h2, 32'h3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA, 2);
      add_vec("madd_neg", MDU_MADD, 32'hFFFF_FFFF, 32'h4, 64'hA, 64'h6, 2);
`else
      add_vec("maddu_off", MDU_MADDU, 32'h1, 32'h1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1);
      add_vec("msub_off", MDU_MSUB, 32'h2, 32'h3, 64'h0000_1234_0000_5678, 64'h0000_1234_0000_5678, 1);
      add_vec("madd_off", MDU_MADD, 32'hFFFF_FFFF, 32'h4, 64'hA, 64'hA, 1);
`endif
      add_vec("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 34);
      add_vec("divu_zero", MDU_DIVU, 32'd100, 32'h0, 64'h0, 64'h0000_0064_FFFF_FFFF, 1);
      add_vec("divu_big", MDU_DIVU, 32'hFFFF_FFFF, 32'd10, 64'h0, 64'h0000_0005_1999_9999, 34);
      add_vec("div_negb", MDU_DIV, 32'h7, 32'hFFFF_FFFE, 64'h0, 64'h0000_0001_FFFF_FFFD, 34);
      add_vec("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_8000_0000, 34);
      add_vec("div_zero", MDU_DIV, 32'hFFFF_FFF9, 32'h0, 64'h0, 64'hFFFF_FFF9_FFFF_FFFF, 1);
      for (int i = 0; i < 3; i++) begin
         logic [W-1:0] a, b;
         a = $urandom; b = $urandom;
         add_vec("multu_rnd", MDU_MULTU, a, b, 64'h0, 64'(a) * 64'(b), 2);
         b = b >> (i * 8);
         if (b == 0) b = 32'd3;
         add_vec("divu_rnd", MDU_DIVU, a, b, 64'h0, {a % b, a / b}, 34);
      end

      repeat (3) @(posedge clk); #1;
      check("reset outputs", {busy_o, ready_o, result_o[61:0]}, 64'd0);
      @(negedge clk); rst = 1'b1;

      foreach (vecs[i]) run_op(vecs[i]);

      // Annul has priority over start in IDLE.
      @(negedge clk); op_i = MDU_MULTU; opa_i = 32'd3; opb_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
      @(posedge clk); #1;
      check("annul_idle busy", {63'd0, busy_o}, 64'd0);
      @(negedge clk); start_i = 1'b0; annul_i = 1'b0;

      // DIVU abandoned by annul at edge 10.
      @(negedge clk); op_i = MDU_DIVU; opa_i = 32'd1000; opb_i = 32'd7; start_i = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
      check("annul busy", {62'd0, busy_o, ready_o}, 64'd0);
      @(negedge clk); annul_i = 1'b0;
      ready_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (ready_o) ready_seen++;
      end
      check("annul no_ready", 64'(ready_seen), 64'd0);
      v.name = "after_annul"; v.op = MDU_MULTU; v.a = 32'd3; v.b = 32'd5; v.hilo = 64'h0; v.res = 64'd15; v.lat = 2;
      run_op(v);

      // Reset in the middle of a divide, start held across the reset.
      @(negedge clk); op_i = MDU_DIV; opa_i = 32'hFFFF_FFF9; opb_i = 32'h2; hilo_i = '0; start_i = 1'b1;
      repeat (6) @(posedge clk); #1;
      check("mid_div busy", {63'd0, busy_o}, 64'd1);
      rst = 1'b0; #1;
      check("mid_div reset", {busy_o, ready_o, result_o[61:0]}, 64'd0);
      check("mid_div reset_hi", {62'd0, result_o[63:62]}, 64'd0);
      @(negedge clk); rst = 1'b1;
      sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
      measure("restart_div", 34);

      check("scoreboard empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
